traf_phase_sched: RTL
=====================

# traf_phase_sched

Request-driven phase scheduler for the four-way intersection. It latches vehicle-sensor requests from the North, East, South and West approaches and grants green to one approach at a time in round-robin order. Each grant is sequenced through timed GREEN, YELLOW and ALL_RED phases. It drives the per-approach 2-bit light codes and replaces the fixed-rotation traffic-light controller at the top of the intersection design.

## Interface
- CLK_PER_TICK, 50_000_000: clk cycles per timing tick (1 s at 50 MHz)
- GREEN_TICKS, 10: green duration in ticks (≥1)
- YELLOW_TICKS, 3: yellow duration in ticks (≥1)
- ALLRED_TICKS, 1: all-red clearance duration in ticks (≥1)
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- req  in  4  sensor requests, bit 0=N, 1=E, 2=S, 3=W; level or pulse, sampled every clk
- North  out  2  light code: 00 red, 01 yellow, 10 green (11 never driven)
- East  out  2  as North
- South  out  2  as North
- West  out  2  as North
- active_dir  out  2  index of the granted or last-granted approach
- busy  out  1  high in GREEN or YELLOW

## Operation
- Reset state:
  - all lights 00
  - state ALL_RED, phase timer = ALLRED_TICKS
  - prescaler 0, pending 0000
  - rr_ptr 0 (North), active_dir 0, busy 0
- Prescaler:
  - counts 0..CLK_PER_TICK-1 and wraps
  - tick = (prescaler == CLK_PER_TICK-1)
  - never cleared by phase changes
- Pending latch:
  - pending[i] is set when req[i] is high.
  - Exception: while approach i is GREEN, req[i] is ignored.
  - pending[i] is cleared on the edge where approach i is granted.
  - Grant and req[i] on the same edge: the clear wins.
- Phase timer:
  - loaded with the phase length on phase entry
  - decrements on tick
  - the phase ends on the edge where tick=1 and timer=1
- States:
  - ALL_RED, on expiry: search pending from rr_ptr upward, modulo 4. First hit g: enter GREEN, active_dir=g, pending[g] cleared, rr_ptr=g+1 mod 4, timer=GREEN_TICKS. No hit: stay in ALL_RED with timer=1, so the search repeats on every tick.
  - GREEN → YELLOW, timer=YELLOW_TICKS.
  - YELLOW → ALL_RED, timer=ALLRED_TICKS.
- Lights:
  - the active_dir approach shows 10 in GREEN and 01 in YELLOW
  - every other approach shows 00 at all times
  - ALL_RED: all approaches 00
- Invariant: at most one approach is non-red in any cycle.

## Timing
- All outputs are registered and change only on the edge that ends a phase.
- Phase lengths in clk cycles, exact:
  - GREEN: GREEN_TICKS·CLK_PER_TICK
  - YELLOW: YELLOW_TICKS·CLK_PER_TICK
  - ALL_RED: ALLRED_TICKS·CLK_PER_TICK, or a longer multiple of CLK_PER_TICK while idle
- First possible green: on the edge ending cycle ALLRED_TICKS·CLK_PER_TICK-1, counting from the first cycle with reset low. This requires pending to be set before that edge.
- Request-to-grant latency: the req must be seen at least one cycle before the deciding edge. A req on the deciding edge itself is latched and is not granted on that edge.
- Reset asserted mid-phase: on the next edge all lights return to 00 and all reset values are restored. The interrupted phase is not completed.
- Counter widths: prescaler is $clog2(CLK_PER_TICK) bits; the timer is wide enough for the largest *_TICKS value.

## Structure
- Shared package traf_pkg holds:
  - light-code constants LIGHT_RED, LIGHT_YELLOW, LIGHT_GREEN
  - direction indices DIR_N, DIR_E, DIR_S, DIR_W
  - the phase-state enum: ALL_RED, GREEN, YELLOW
- Sub-module traf_tick_gen holds the prescaler and emits tick. Its only parameter is CLK_PER_TICK.
- Scheduler FSM, pending latch, round-robin search and light decode stay in traf_phase_sched.

## Test plan
All scenarios use CLK_PER_TICK=4, GREEN_TICKS=3, YELLOW_TICKS=2, ALLRED_TICKS=1.
- Idle: release reset with req=0000 for 100 cycles. All lights stay 00, busy=0, active_dir=0.
- Single request: pulse req=0100 (S) for one cycle at cycle 1.
  - South=10 from cycle 4 to 15
  - South=01 from cycle 16 to 23
  - 00 from cycle 24
  - other approaches stay 00 throughout
- Round robin: hold req=1111 from reset release. Grants follow N, E, S, W, N. Each green starts 24 cycles after the previous one (12 green + 8 yellow + 4 all-red).
- Green-approach masking: raise req[0] while North is green. No second North grant follows unless req[0] is reasserted after North leaves GREEN.
- Simultaneous grant and request: pulse req=0001 exactly on the granting edge. pending[0] ends cleared; South's later pending request is served first.
- Reset mid-green: assert reset for one cycle at the midpoint of East green. All lights are 00 on the next edge; rr_ptr=0 and pending=0000 afterwards.

Source files
------------

// File: rtl/traf_pkg.sv
// rtl/traf_pkg.sv - shared light codes, direction indices and phase enum for the intersection
package traf_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2
  } phase_t;

  // Largest of three phase lengths, used to size the phase timer
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/traf_tick_gen.sv
// rtl/traf_tick_gen.sv - free-running prescaler producing one tick per CLK_PER_TICK cycles
module traf_tick_gen #(
  parameter int CLK_PER_TICK = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_TICK - 1);

  logic [PW-1:0] count;

  // Count 0..CLK_PER_TICK-1 and wrap; phase changes never touch it
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + PW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/traf_phase_sched.sv
// rtl/traf_phase_sched.sv - request-latched round-robin GREEN/YELLOW/ALL_RED phase scheduler
module traf_phase_sched
  import traf_pkg::*;
#(
  parameter int CLK_PER_TICK = 50_000_000,
  parameter int GREEN_TICKS  = 10,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [1:0] North,
  output logic [1:0] East,
  output logic [1:0] South,
  output logic [1:0] West,
  output logic [1:0] active_dir,
  output logic       busy
);

  localparam int TMAX = max3(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS);
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [TW-1:0] T_GREEN  = TW'(GREEN_TICKS);
  localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_TICKS);
  localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_TICKS);

  phase_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      pending_q, pending_d, green_mask;
  logic [1:0]      rr_q, rr_d, dir_q, dir_d;
  logic [1:0]      idx, gidx;
  logic            found, tick;
  logic [3:0][1:0] lights_q, lights_d;
  logic            busy_q, busy_d;

  traf_tick_gen #(.CLK_PER_TICK(CLK_PER_TICK)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // State register: phase, timer, pending latch, pointer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ALL_RED;
      timer_q   <= T_ALLRED;
      pending_q <= '0;
      rr_q      <= DIR_N;
      dir_q     <= DIR_N;
      lights_q  <= {4{LIGHT_RED}};
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      dir_q     <= dir_d;
      lights_q  <= lights_d;
      busy_q    <= busy_d;
    end
  end

  // Round-robin search of the latched requests starting at rr_q; a req on the
  // deciding edge is not yet in pending_q, so it cannot win that edge
  always_comb begin
    found = 1'b0;
    gidx  = rr_q;
    idx   = rr_q;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end

  // Next-state, pending update and light decode from the next phase
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    rr_d       = rr_q;
    dir_d      = dir_q;
    green_mask = (state_q == GREEN) ? (4'b0001 << dir_q) : 4'b0000;
    pending_d  = pending_q | (req & ~green_mask);

    if (tick) begin
      if (timer_q == T_ONE) begin
        case (state_q)
          ALL_RED: begin
            if (found) begin
              state_d         = GREEN;
              dir_d           = gidx;
              pending_d[gidx] = 1'b0;
              rr_d            = gidx + 2'd1;
              timer_d         = T_GREEN;
            end else begin
              timer_d = T_ONE;
            end
          end
          GREEN: begin
            state_d = YELLOW;
            timer_d = T_YELLOW;
          end
          default: begin
            state_d = ALL_RED;
            timer_d = T_ALLRED;
          end
        endcase
      end else begin
        timer_d = timer_q - T_ONE;
      end
    end

    for (int i = 0; i < 4; i++) begin
      lights_d[i] = LIGHT_RED;
      if (2'(i) == dir_d) begin
        if (state_d == GREEN)       lights_d[i] = LIGHT_GREEN;
        else if (state_d == YELLOW) lights_d[i] = LIGHT_YELLOW;
      end
    end
    busy_d = (state_d == GREEN) || (state_d == YELLOW);
  end

  assign North      = lights_q[DIR_N];
  assign East       = lights_q[DIR_E];
  assign South      = lights_q[DIR_S];
  assign West       = lights_q[DIR_W];
  assign active_dir = dir_q;
  assign busy       = busy_q;

endmodule
